// File: rtl/sha256_multiblock_core_if.sv
// Word-stream handshake between the Avalon wrapper and the SHA-256 core.
// The wrapper presents one message word per accepted request; last_block travels with word 15.
interface sha256_multiblock_core_if;
   logic [31:0] wrapper_data;
   logic        wrapper_data_valid;
   logic        wrapper_data_request;
   logic        last_block;

   modport master (
      output wrapper_data,
      output wrapper_data_valid,
      output last_block,
      input  wrapper_data_request
   );

   modport slave (
      input  wrapper_data,
      input  wrapper_data_valid,
      input  last_block,
      output wrapper_data_request
   );
endinterface

// File: rtl/sha256_multiblock_core.sv
// SHA-256/SHA-224 engine with multi-block chaining and UNROLL rounds per clock.
// Message words are stored in a 16-entry window that also serves as the expanding schedule.
module sha256_multiblock_core #(
   parameter int unsigned UNROLL      = 1,
   parameter bit          SUPPORT_224 = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      mode_224,
   sha256_multiblock_core_if.slave   bus,
   output logic [255:0]              hash_out,
   output logic                      done,
   output logic                      busy
);

   generate
      if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
         $error("sha256_multiblock_core: UNROLL must be 1, 2 or 4");
      end
   endgenerate

   localparam int unsigned NCYC = 64 / UNROLL;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic [31:0] h_q  [8];
   logic [31:0] r_q  [8];
   logic [31:0] r_nx [8];
   logic [31:0] w_q  [16];
   logic [31:0] w_nx [16];
   logic [3:0]  cnt_q;
   logic [5:0]  rnd_q;
   logic        last_q;
   logic        mode_q;
   logic        req;
   logic        accept;
   logic        use_224;
   logic [31:0] t1, t2, w_new;
   logic [5:0]  kidx;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   assign accept  = req & bus.wrapper_data_valid;
   assign use_224 = SUPPORT_224 & mode_224;
   assign bus.wrapper_data_request = req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_LOAD;
         S_LOAD:   if (accept && cnt_q == 4'd15) state_nx = S_ROUND;
         S_ROUND:  if (rnd_q == 6'(NCYC - 1)) state_nx = S_UPDATE;
         S_UPDATE: state_nx = last_q ? S_DONE : S_LOAD;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req  = (state == S_LOAD);
      busy = (state != S_IDLE);
   end

   // Window slot 0 is always the current W; each round appends the next expanded word.
   always_comb begin
      r_nx  = r_q;
      w_nx  = w_q;
      t1    = '0;
      t2    = '0;
      w_new = '0;
      kidx  = '0;
      for (int unsigned u = 0; u < UNROLL; u++) begin
         kidx  = 6'(32'(rnd_q) * UNROLL + u);
         t1    = r_nx[7] + big_sig1(r_nx[4]) + ((r_nx[4] & r_nx[5]) ^ (~r_nx[4] & r_nx[6]))
                 + K[kidx] + w_nx[0];
         t2    = big_sig0(r_nx[0]) + ((r_nx[0] & r_nx[1]) ^ (r_nx[0] & r_nx[2]) ^ (r_nx[1] & r_nx[2]));
         w_new = small_sig1(w_nx[14]) + w_nx[9] + small_sig0(w_nx[1]) + w_nx[0];
         for (int unsigned j = 0; j < 15; j++) begin
            w_nx[j] = w_nx[j + 1];
         end
         w_nx[15] = w_new;
         r_nx[7]  = r_nx[6];
         r_nx[6]  = r_nx[5];
         r_nx[5]  = r_nx[4];
         r_nx[4]  = r_nx[3] + t1;
         r_nx[3]  = r_nx[2];
         r_nx[2]  = r_nx[1];
         r_nx[1]  = r_nx[0];
         r_nx[0]  = t1 + t2;
      end
   end

   // done and hash_out are registered out of DONE, so both appear together one edge later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 8; i++) begin
            h_q[i] <= '0;
            r_q[i] <= '0;
         end
         for (int unsigned i = 0; i < 16; i++) begin
            w_q[i] <= '0;
         end
         cnt_q    <= '0;
         rnd_q    <= '0;
         last_q   <= 1'b0;
         mode_q   <= 1'b0;
         hash_out <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int unsigned i = 0; i < 8; i++) begin
                     h_q[i] <= use_224 ? IV224[i] : IV256[i];
                  end
                  mode_q <= use_224;
                  cnt_q  <= '0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  w_q[cnt_q] <= bus.wrapper_data;
                  cnt_q      <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     last_q <= bus.last_block;
                     r_q    <= h_q;
                     rnd_q  <= '0;
                  end
               end
            end
            S_ROUND: begin
               r_q   <= r_nx;
               w_q   <= w_nx;
               rnd_q <= rnd_q + 6'd1;
            end
            S_UPDATE: begin
               for (int unsigned i = 0; i < 8; i++) begin
                  h_q[i] <= h_q[i] + r_q[i];
               end
               cnt_q <= '0;
            end
            S_DONE: begin
               hash_out <= {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6],
                            mode_q ? 32'h0 : h_q[7]};
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Directed bench: FIPS 180 reference vectors on UNROLL=1/2/4 instances sharing one word stream.
module tb_sha256_multiblock_core;

   localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start0, start12, mode;
   logic [31:0]  data;
   logic         valid, last;
   logic [255:0] hash_v [3];
   logic         done_v [3];
   logic         busy_v [3];
   logic [31:0]  blk_abc [16];
   logic [31:0]  blk_m1  [16];
   logic [31:0]  blk_m2  [16];
   int           lat     [3];
   int           ndone   [3];
   bit           busy_ok [3];
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   sha256_multiblock_core_if if0 ();
   sha256_multiblock_core_if if1 ();
   sha256_multiblock_core_if if2 ();

   assign if0.wrapper_data = data;
   assign if1.wrapper_data = data;
   assign if2.wrapper_data = data;
   assign if0.wrapper_data_valid = valid;
   assign if1.wrapper_data_valid = valid;
   assign if2.wrapper_data_valid = valid;
   assign if0.last_block = last;
   assign if1.last_block = last;
   assign if2.last_block = last;

   sha256_multiblock_core #(.UNROLL(1), .SUPPORT_224(1'b1)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .mode_224(mode), .bus(if0),
      .hash_out(hash_v[0]), .done(done_v[0]), .busy(busy_v[0]));
   sha256_multiblock_core #(.UNROLL(2), .SUPPORT_224(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start12), .mode_224(mode), .bus(if1),
      .hash_out(hash_v[1]), .done(done_v[1]), .busy(busy_v[1]));
   sha256_multiblock_core #(.UNROLL(4), .SUPPORT_224(1'b1)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start12), .mode_224(mode), .bus(if2),
      .hash_out(hash_v[2]), .done(done_v[2]), .busy(busy_v[2]));

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start_msg(input bit m, input bit all);
      @(negedge clk);
      mode   = m;
      start0 = 1'b1;
      if (all) start12 = 1'b1;
      @(negedge clk);
      start0  = 1'b0;
      start12 = 1'b0;
   endtask

   // Returns 1 ns after the edge that accepts word 15.
   task automatic send_block(input logic [31:0] blk [16], input bit lst, input bit gaps, input int pulse_at);
      int n;
      bit to;
      to = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         data  = blk[i];
         last  = (i == 15) ? lst : 1'($urandom);
         valid = 1'b1;
         if (i == pulse_at) begin
            start0 = 1'b1;
            mode   = ~mode;
         end
         n = 0;
         while (!if0.wrapper_data_request && n < 300) begin
            @(negedge clk);
            n++;
         end
         if (n >= 300) to = 1'b1;
         @(posedge clk);
         #1;
         valid  = 1'b0;
         start0 = 1'b0;
      end
      check_val("req_wait", 256'(to), 256'(0));
   endtask

   task automatic watch(input int max_edges, input bit stop0);
      for (int k = 0; k < 3; k++) begin
         lat[k]     = 0;
         ndone[k]   = 0;
         busy_ok[k] = 1'b1;
      end
      for (int n = 1; n <= max_edges; n++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            if (done_v[k]) begin
               ndone[k]++;
               if (lat[k] == 0) lat[k] = n;
            end else if (lat[k] == 0 && !busy_v[k]) begin
               busy_ok[k] = 1'b0;
            end
         end
         if (stop0 && done_v[0]) break;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start0  = 1'b0;
      start12 = 1'b0;
      mode    = 1'b0;
      data    = '0;
      valid   = 1'b0;
      last    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         blk_abc[i] = '0;
         blk_m2[i]  = '0;
      end
      blk_abc[0]  = 32'h61626380;
      blk_abc[15] = 32'h00000018;
      blk_m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      blk_m2[15] = 32'h000001c0;

      repeat (3) @(negedge clk);
      check_val("rst_hash", hash_v[0], '0);
      check_val("rst_done", 256'(done_v[0]), 256'(0));
      check_val("rst_busy", 256'(busy_v[0]), 256'(0));
      check_val("rst_req", 256'(if0.wrapper_data_request), 256'(0));
      reset_n = 1'b1;

      // Valid while idle must not be consumed.
      @(negedge clk);
      data  = 32'hdeadbeef;
      valid = 1'b1;
      repeat (3) @(negedge clk);
      valid = 1'b0;

      // "abc" on all three unroll widths at once.
      start_msg(1'b0, 1'b1);
      send_block(blk_abc, 1'b1, 1'b0, -1);
      watch(80, 1'b0);
      check_val("abc_u1", hash_v[0], ABC256);
      check_val("abc_u2", hash_v[1], ABC256);
      check_val("abc_u4", hash_v[2], ABC256);
      check_val("lat_u1", 256'(lat[0]), 256'(66));
      check_val("lat_u2", 256'(lat[1]), 256'(34));
      check_val("lat_u4", 256'(lat[2]), 256'(18));
      check_val("ndone_u1", 256'(ndone[0]), 256'(1));
      check_val("ndone_u2", 256'(ndone[1]), 256'(1));
      check_val("ndone_u4", 256'(ndone[2]), 256'(1));
      check_val("busy_u1", 256'(busy_ok[0]), 256'(1));
      check_val("busy_u2", 256'(busy_ok[1]), 256'(1));
      check_val("busy_u4", 256'(busy_ok[2]), 256'(1));
      check_val("idle_after", 256'(busy_v[0]), 256'(0));

      // SHA-224 of "abc".
      start_msg(1'b1, 1'b0);
      send_block(blk_abc, 1'b1, 1'b0, -1);
      watch(80, 1'b0);
      check_val("abc_224", hash_v[0], ABC224);
      check_val("lat_224", 256'(lat[0]), 256'(66));

      // Two chained blocks with a gapped word stream.
      start_msg(1'b0, 1'b0);
      send_block(blk_m1, 1'b0, 1'b1, -1);
      send_block(blk_m2, 1'b1, 1'b1, -1);
      watch(80, 1'b0);
      check_val("two_blk", hash_v[0], TWO256);
      check_val("lat_two", 256'(lat[0]), 256'(66));
      check_val("ndone_two", 256'(ndone[0]), 256'(1));

      // Start and mode toggles during LOAD and ROUND are ignored.
      start_msg(1'b0, 1'b0);
      send_block(blk_abc, 1'b1, 1'b0, 8);
      repeat (5) @(negedge clk);
      start0 = 1'b1;
      mode   = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      watch(100, 1'b1);
      check_val("ign_start", hash_v[0], ABC256);
      check_val("ign_done", 256'(ndone[0]), 256'(1));

      // Back-to-back message started in the cycle done is seen.
      start_msg(1'b1, 1'b0);
      check_val("hold_hash", hash_v[0], ABC256);
      check_val("b2b_busy", 256'(busy_v[0]), 256'(1));
      send_block(blk_abc, 1'b1, 1'b0, -1);
      watch(80, 1'b0);
      check_val("b2b_224", hash_v[0], ABC224);

      // Asynchronous reset mid-ROUND.
      start_msg(1'b0, 1'b0);
      send_block(blk_abc, 1'b1, 1'b0, -1);
      repeat (20) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_val("arst_hash", hash_v[0], '0);
      check_val("arst_ctl", {253'd0, done_v[0], busy_v[0], if0.wrapper_data_request}, '0);
      @(negedge clk);
      reset_n = 1'b1;
      start_msg(1'b0, 1'b0);
      send_block(blk_abc, 1'b1, 1'b0, -1);
      watch(80, 1'b0);
      check_val("post_rst", hash_v[0], ABC256);
      check_val("lat_post", 256'(lat[0]), 256'(66));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
